// File: rtl/muldiv_unit.sv
// RV32M multi-cycle multiply/divide unit for the execute stage.
// Radix-2 shift-add multiplier and restoring divider sharing one accumulator.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [5:0]            ALU_Control,
  input  logic [DATA_WIDTH-1:0] operand_A,
  input  logic [DATA_WIDTH-1:0] operand_B,
  output logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] ALU_result,
  output logic                  zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [2:0]     r_f3;
  logic           r_neg;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [2*W-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_res;

  logic           w_accept;
  logic [2:0]     w_f3;
  logic           w_md;
  logic           w_sa;
  logic           w_sb;
  logic           w_asg;
  logic           w_bsg;
  logic           w_neg;
  logic           w_div0;
  logic           w_ovf;
  logic           w_fast;
  logic [W-1:0]   w_abs_a;
  logic [W-1:0]   w_abs_b;
  logic [W-1:0]   w_fast_res;

  assign ready    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign valid    = (r_state == S_DONE);
  assign w_accept = start & ready & ~flush;

  assign w_f3  = ALU_Control[2:0];
  assign w_md  = (ALU_Control[5:3] == 3'b100);
  assign w_sa  = operand_A[W-1];
  assign w_sb  = operand_B[W-1];
  assign w_asg = w_md & (w_f3 inside {F_MUL, F_MULH, F_MULHSU, F_DIV, F_REM});
  assign w_bsg = w_md & (w_f3 inside {F_MUL, F_MULH, F_DIV, F_REM});

  assign w_abs_a = (w_asg & w_sa) ? -operand_A : operand_A;
  assign w_abs_b = (w_bsg & w_sb) ? -operand_B : operand_B;

  // Remainder takes the dividend's sign; everything else the XOR.
  assign w_neg = (w_f3 == F_REM) ? w_sa
               : ((w_asg & w_sa) ^ (w_bsg & w_sb));

  assign w_div0 = w_md & w_f3[2] & (operand_B == '0);
  assign w_ovf  = w_md & ((w_f3 == F_DIV) || (w_f3 == F_REM))
                & (operand_A == {1'b1, {(W-1){1'b0}}})
                & (&operand_B);
  assign w_fast = ~w_md | w_div0 | w_ovf;

  always_comb begin
    w_fast_res = '0;
    unique case (1'b1)
      w_div0:  w_fast_res = w_f3[1] ? operand_A : '1;
      w_ovf:   w_fast_res = w_f3[1] ? '0 : operand_A;
      default: w_fast_res = '0;
    endcase
  end

  logic [W-1:0]   w_addend;
  logic [W:0]     w_sum;
  logic [W:0]     w_shr;
  logic           w_ge;
  logic [W-1:0]   w_sub;
  logic [2*W-1:0] w_step;

  assign w_addend = r_acc[0] ? r_a : '0;
  assign w_sum    = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_addend};
  assign w_shr    = {r_acc[2*W-1:W], r_acc[W-1]};
  assign w_ge     = (w_shr >= {1'b0, r_b});
  assign w_sub    = w_shr[W-1:0] - r_b;

  // Upper half: partial product / remainder; lower: multiplier / quotient.
  assign w_step = r_f3[2]
    ? {(w_ge ? w_sub : w_shr[W-1:0]), r_acc[W-2:0], w_ge}
    : {w_sum, r_acc[W-1:1]};

  logic [2*W-1:0] w_prod;
  logic [W-1:0]   w_quo;
  logic [W-1:0]   w_rem;
  logic [W-1:0]   w_fix_res;

  assign w_prod = r_neg ? -r_acc : r_acc;
  assign w_quo  = r_neg ? -r_acc[W-1:0] : r_acc[W-1:0];
  assign w_rem  = r_neg ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];

  always_comb begin
    w_fix_res = '0;
    unique case (r_f3)
      F_MUL:                     w_fix_res = w_prod[W-1:0];
      F_MULH, F_MULHSU, F_MULHU: w_fix_res = w_prod[2*W-1:W];
      F_DIV, F_DIVU:             w_fix_res = w_quo;
      default:                   w_fix_res = w_rem;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) w_next = w_fast ? S_DONE : S_CALC;
        else          w_next = S_IDLE;
      end
      S_CALC:  if (r_cnt == CW'(W - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_f3  <= '0;
      r_neg <= 1'b0;
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_cnt <= '0;
      r_res <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_f3  <= w_f3;
        r_neg <= w_neg;
        r_a   <= w_abs_a;
        r_b   <= w_abs_b;
        r_acc <= {{W{1'b0}}, (w_f3[2] ? w_abs_a : w_abs_b)};
        r_cnt <= '0;
        if (w_fast) r_res <= w_fast_res;
      end else if (r_state == S_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CW'(1);
      end else if (r_state == S_FIX) begin
        r_res <= w_fix_res;
      end
    end
  end

  assign ALU_result = r_res;
  assign zero       = (r_res == '0);

endmodule
